// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, next-PC select codes,
// immediate-extender select codes and the halt opcode.
package cpu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned JIDX_W   = 26;

    // Opcode that stops instruction fetch once retired.
    localparam logic [OP_W-1:0] HALT_OP = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_HOLD   = 2'b10,
        ST_HALTED = 2'b11
    } fetch_state_e;

    // Next-PC source select driven by control.
    typedef enum logic [1:0] {
        PC_NEXT   = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_HOLD   = 2'b11
    } pc_src_e;

    // Immediate extender mode select, kept beside PCSrc for the control unit.
    typedef enum logic [1:0] {
        EXT_ZERO  = 2'b00,
        EXT_SIGN  = 2'b01,
        EXT_UPPER = 2'b10
    } ext_sel_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC generator.
// Ports: pc_in (current PC), ext_imm (extended immediate), jump_idx (IR[25:0]),
//        pc_src (select) -> pc_plus4, next_pc. All arithmetic wraps modulo 2^32.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0]   pc_in,
    input  logic [XLEN-1:0]   ext_imm,
    input  logic [JIDX_W-1:0] jump_idx,
    input  pc_src_e           pc_src,
    output logic [XLEN-1:0]   pc_plus4,
    output logic [XLEN-1:0]   next_pc
);

    assign pc_plus4 = pc_in + XLEN'(4);

    // Select the next fetch address; every source is word-aligned.
    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            PC_NEXT:   next_pc = pc_plus4;
            PC_BRANCH: next_pc = pc_plus4 + (ext_imm << 2);
            PC_JUMP:   next_pc = {pc_plus4[31:28], jump_idx, 2'b00};
            PC_HOLD:   next_pc = pc_in;
            default:   next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch stage.
// Ports: CLK/Reset (sync, active-high); PCWre/PCSrc from control; ext_imm from the
//        extender; imem_req/imem_addr/imem_ack/imem_rdata instruction-memory port;
//        instr_out/instr_valid instruction register; pc_out, pc_plus4, halted.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = cpu_pkg::HALT_OP
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ext_imm,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        halted
);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             halted_q, halted_d;
    logic [XLEN-1:0]  next_pc;

    next_pc_calc u_next_pc_calc (
        .pc_in    (pc_q),
        .ext_imm  (ext_imm),
        .jump_idx (instr_q[JIDX_W-1:0]),
        .pc_src   (pc_src_e'(PCSrc)),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

    // Fetch sequencing: request, capture on ack, wait for consume, advance PC.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (PCWre) begin
                    valid_d = 1'b0;
                    // A retired halt freezes the PC at the halt instruction.
                    if (instr_q[31:26] == HALT_OP) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALTED;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= {RESET_PC[31:2], 2'b00};
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: directed scenarios with literal expectations,
// then randomized stimulus, all checked every cycle against a transaction model.
module tb_fetch_pc_unit;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        PCWre = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic [31:0] ext_imm = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        halted;

    fetch_pc_unit dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .PCWre       (PCWre),
        .PCSrc       (PCSrc),
        .ext_imm     (ext_imm),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .halted      (halted)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the fetch stage is doing, in plain terms.
    localparam int M_IDLE = 0, M_WAITMEM = 1, M_HAVEINSTR = 2, M_STOPPED = 3;
    int          m_mode = M_IDLE;
    logic [31:0] m_pc = '0;
    logic [31:0] m_ir = '0;
    logic        m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_step();
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (Reset) begin
            m_mode = M_IDLE; m_pc = 32'h0; m_ir = 32'h0; m_valid = 1'b0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_WAITMEM;
        end else if (m_mode == M_WAITMEM) begin
            if (imem_ack) begin
                m_ir = imem_rdata; m_valid = 1'b1; m_mode = M_HAVEINSTR;
            end
        end else if (m_mode == M_HAVEINSTR && PCWre) begin
            m_valid = 1'b0;
            if (m_ir[31:26] == 6'b111111) begin
                m_mode = M_STOPPED;
            end else begin
                m_mode = M_WAITMEM;
                if (PCSrc == 2'd0)      m_pc = seq;
                else if (PCSrc == 2'd1) m_pc = seq + ext_imm * 32'd4;
                else if (PCSrc == 2'd2) m_pc = (seq & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 32'd4);
            end
        end
    endtask

    task automatic compare_all();
        chk("imem_req",    {31'b0, imem_req},    {31'b0, m_mode == M_WAITMEM});
        chk("imem_addr",   imem_addr,            m_pc);
        chk("pc_out",      pc_out,               m_pc);
        chk("pc_plus4",    pc_plus4,             m_pc + 32'd4);
        chk("instr_out",   instr_out,            m_ir);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        chk("halted",      {31'b0, halted},      {31'b0, m_mode == M_STOPPED});
    endtask

    // One clock: model sees the same inputs as the DUT, outputs checked 1 unit later.
    task automatic cyc();
        model_step();
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        Reset = 1'b1; imem_ack = 1'b0; PCWre = 1'b0;
        cyc();
        Reset = 1'b0;
    endtask

    task automatic fetch_instr(input logic [31:0] word, input int waits);
        imem_ack = 1'b0;
        for (int i = 0; i < waits; i++) cyc();
        imem_ack = 1'b1; imem_rdata = word;
        cyc();
        imem_ack = 1'b0;
    endtask

    task automatic consume(input logic [1:0] src, input logic [31:0] imm);
        PCWre = 1'b1; PCSrc = src; ext_imm = imm;
        cyc();
        PCWre = 1'b0;
    endtask

    initial begin
        // Reset state.
        do_reset();
        chk("rst pc", pc_out, 32'h0);
        chk("rst instr", instr_out, 32'h0);
        chk("rst req/valid/halt", {29'b0, imem_req, instr_valid, halted}, 32'h0);

        // First fetch with zero-wait memory.
        cyc();
        chk("first req", {31'b0, imem_req}, 32'h1);
        chk("first addr", imem_addr, 32'h0);
        fetch_instr(32'h2001_0005, 0);
        chk("first valid", {31'b0, instr_valid}, 32'h1);
        chk("first instr", instr_out, 32'h2001_0005);
        consume(2'b00, 32'h0);
        chk("seq pc", pc_out, 32'h4);

        // Jump to 0x10, then branch backwards.
        fetch_instr(32'h0800_0004, 0);
        consume(2'b10, 32'h0);
        chk("jump to 0x10", pc_out, 32'h10);
        fetch_instr(32'h1234_5678, 0);
        consume(2'b01, 32'hFFFF_FFFE);
        chk("branch neg", pc_out, 32'hC);

        // Back to 0x10, then branch forwards.
        fetch_instr(32'h0800_0004, 0);
        consume(2'b10, 32'h0);
        fetch_instr(32'h1111_2222, 0);
        consume(2'b01, 32'h0000_0003);
        chk("branch pos", pc_out, 32'h20);

        // Long branch into the top region, then a region-relative jump.
        fetch_instr(32'h1000_0000, 0);
        consume(2'b01, 32'h3BFF_FFF9);
        chk("long branch", pc_out, 32'hF000_0008);
        fetch_instr(32'h0800_0040, 0);
        consume(2'b10, 32'h0);
        chk("jump region", pc_out, 32'hF000_0100);

        // Five wait states: request held, address stable, nothing valid.
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("wait req", {31'b0, imem_req}, 32'h1);
            chk("wait addr", imem_addr, 32'hF000_0100);
            chk("wait valid", {31'b0, instr_valid}, 32'h0);
        end
        fetch_instr(32'h0000_ABCD, 0);

        // Spurious ack while holding an instruction.
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc(); cyc();
        imem_ack = 1'b0;
        chk("spurious ack", instr_out, 32'h0000_ABCD);

        // Reach the top of memory, then wrap.
        consume(2'b01, 32'h03FF_FFBE);
        chk("near top", pc_out, 32'hFFFF_FFFC);
        chk("plus4 wrap", pc_plus4, 32'h0);
        fetch_instr(32'h2222_3333, 1);
        consume(2'b00, 32'h0);
        chk("pc wrap", pc_out, 32'h0);

        // Hold select re-fetches the same address.
        fetch_instr(32'h3333_4444, 0);
        consume(2'b11, 32'h0);
        chk("hold pc", pc_out, 32'h0);
        chk("hold refetch", {31'b0, imem_req}, 32'h1);

        // Halt and its absorbing behaviour.
        fetch_instr(32'hFC00_0000, 0);
        consume(2'b00, 32'h0);
        chk("halted", {31'b0, halted}, 32'h1);
        chk("halt req", {31'b0, imem_req}, 32'h0);
        chk("halt pc", pc_out, 32'h0);
        PCWre = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0001; PCSrc = 2'b01; ext_imm = 32'h40;
        for (int i = 0; i < 3; i++) cyc();
        PCWre = 1'b0; imem_ack = 1'b0;
        chk("halt sticky", {31'b0, halted}, 32'h1);
        chk("halt pc sticky", pc_out, 32'h0);
        do_reset();
        chk("unhalt", {31'b0, halted}, 32'h0);
        chk("unhalt pc", pc_out, 32'h0);

        // Reset beats a simultaneous ack.
        cyc();
        Reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        Reset = 1'b0; imem_ack = 1'b0;
        chk("rst+ack instr", instr_out, 32'h0);
        chk("rst+ack valid", {31'b0, instr_valid}, 32'h0);
        chk("rst+ack idle", {31'b0, imem_req}, 32'h0);
        cyc();
        chk("rst+ack refetch", {31'b0, imem_req}, 32'h1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            Reset    = ($urandom_range(0, 99) < 3);
            PCWre    = ($urandom_range(0, 2) != 0);
            PCSrc    = 2'($urandom_range(0, 3));
            ext_imm  = $urandom;
            imem_ack = ($urandom_range(0, 1) == 1);
            imem_rdata = $urandom;
            if ($urandom_range(0, 9) == 0) imem_rdata[31:26] = 6'b111111;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and instruction-fetch stage of the MIPS datapath.
- Holds the PC and fetches instructions over a request/acknowledge instruction-memory port.
- Latches each instruction into an instruction register. IR[15:0] drives the immediate extender's in_num.
- Consumes the extender's 32-bit output to form branch targets, and also forms jump targets.

Parameters:
- RESET_PC, 32'h00000000, PC value after reset; bits [1:0] must be 0.
- HALT_OP, 6'b111111, opcode that stops fetching.

Ports:
- CLK  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- PCWre  in  1  from control; advance PC when the instruction is consumed.
- PCSrc  in  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 hold.
- ext_imm  in  32  extended immediate from the extender.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc_out.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- instr_out  out  32  instruction register.
- instr_valid  out  1  instr_out holds a fetched, unconsumed instruction.
- pc_out  out  32  current PC.
- pc_plus4  out  32  pc_out+4, combinational.
- halted  out  1  halt opcode retired; fetching stopped.

Behaviour:
- Reset: state=IDLE, pc_out=RESET_PC, instr_out=0, instr_valid=0, halted=0, imem_req=0. Reset overrides every other input on the same edge.
- FSM states: IDLE, FETCH, HOLD, HALTED.
  - imem_req=1 only in FETCH (decoded from the registered state).
  - imem_addr=pc_out at all times.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH:
  - Edge with imem_ack=1: instr_out<=imem_rdata, instr_valid<=1, -> HOLD. Latency ack-to-valid is 1 cycle.
  - imem_ack=0: stay in FETCH and hold the request. No timeout.
- HOLD:
  - PCWre=0: hold everything.
  - Edge with PCWre=1 and instr_out[31:26]==HALT_OP: -> HALTED, halted<=1, instr_valid<=0; PC unchanged.
  - Edge with PCWre=1 otherwise: pc_out<=next_pc, instr_valid<=0, -> FETCH.
- next_pc (all arithmetic modulo 2^32, wrap silently):
  - 00: pc_plus4.
  - 01: pc_plus4 + (ext_imm<<2).
  - 10: {pc_plus4[31:28], instr_out[25:0], 2'b00}.
  - 11: pc_out, which re-fetches the same address.
- HALTED: absorbing; only Reset exits. imem_req=0. Ignores PCWre, PCSrc and imem_ack.
- Ignored inputs:
  - imem_ack outside FETCH.
  - PCWre outside HOLD.
- Reset during FETCH with imem_ack=1 on the same edge: reset wins. The data is discarded and instr_out=0.
- Back-to-back flow: ack edge -> HOLD. A PCWre edge the cycle after -> FETCH. This gives a minimum 2 cycles per instruction with a zero-wait memory.
- pc_out[1:0] is always 0: RESET_PC is aligned and every next_pc source is word-aligned.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum (IDLE, FETCH, HOLD, HALTED);
  - PCSrc codes PC_NEXT, PC_BRANCH, PC_JUMP, PC_HOLD;
  - HALT_OP;
  - the extender's ExtSel codes, kept beside PCSrc.
- One combinational sub-module, next_pc_calc: inputs pc_out, ext_imm, instr_out[25:0], PCSrc; outputs pc_plus4 and next_pc.
- The FSM and registers stay in fetch_pc_unit.

Test Plan:
- Reset then zero-wait memory returning 32'h20010005:
  - imem_req rises 1 cycle after reset release, with imem_addr=0.
  - instr_valid=1 and instr_out=32'h20010005 one cycle after ack.
  - PCWre with PCSrc=00 gives pc_out=4.
- Branch at pc_out=32'h10, ext_imm=32'hFFFFFFFE, PCSrc=01, PCWre: pc_out=32'h0000000C. Repeat with ext_imm=32'h00000003: pc_out=32'h20.
- Jump at pc_out=32'hF0000008, instr_out=32'h08000040, PCSrc=10: pc_out=32'hF0000100.
- Memory wait states:
  - imem_ack held low for 5 cycles: imem_req stays high, imem_addr stable, instr_valid=0.
  - Spurious imem_ack during HOLD: instr_out unchanged.
- Halt:
  - instr_out=32'hFC000000 with PCWre: halted=1, imem_req=0, pc_out unchanged.
  - Further PCWre or ack has no effect.
  - Reset returns pc_out=RESET_PC and halted=0.
- Reset asserted on the same edge as imem_ack with imem_rdata=32'hDEADBEEF: instr_out=0, instr_valid=0, state IDLE. PC wrap check: pc_out=32'hFFFFFFFC with PCSrc=00 gives pc_out=0.
